minmax_tracker: RTL
===================

Name: minmax_tracker

Overview:
- Streaming stage directly downstream of the subtract-based unsigned comparator.
- Accepts N-bit unsigned samples over a valid/ready handshake and runs a less-than comparison of each sample against a running minimum and a running maximum.
- Emits one {min, max, count} result per frame of up to FRAME_LEN samples.
- Used to bound operand ranges before arithmetic stages.

Parameters:
- N, 4, sample width in bits (unsigned).
- FRAME_LEN, 8, maximum samples per frame (>= 2).
- CW, $clog2(FRAME_LEN+1), count width (localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample present.
- in_ready  output  1  block can accept a sample.
- in_data  input  N  unsigned sample.
- in_last  input  1  sample is the final one of the frame (qualified by in_valid).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out_min  output  N  smallest sample of the frame.
- out_max  output  N  largest sample of the frame.
- out_count  output  CW  number of samples in the frame (1..FRAME_LEN).

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: in_ready=0 while rst_n low; state=IDLE; out_valid=0; out_min=0; out_max=0; out_count=0; internal cnt=0.
  - in_ready goes to 1 on the first edge after reset release.
- Comparison rule: lt(a,b) = borrow of {1'b0,a} - {1'b0,b}; unsigned, strict.
  - Update min when lt(in_data, min).
  - Update max when lt(max, in_data).
  - Ties keep the earlier sample.
- Accept = in_valid && in_ready.
- FSM states:
  - IDLE: in_ready=1. On accept, min=max=in_data and cnt=1.
    - If in_last, or FRAME_LEN reached (never in IDLE since FRAME_LEN>=2), go to HOLD; otherwise go to ACCUM.
  - ACCUM: in_ready=1. On accept, apply the comparison and cnt=cnt+1.
    - If in_last or cnt+1==FRAME_LEN, go to HOLD; otherwise stay in ACCUM.
  - HOLD: in_ready=0. out_valid=1 with out_min/out_max/out_count frozen.
    - On out_valid && out_ready, go to IDLE and deassert out_valid the next cycle.
- Output registers load on the edge that accepts the frame's final sample, so out_valid asserts exactly 1 cycle after the final handshake.
- No bypass: a new frame cannot be accepted in the same cycle the result is consumed. in_ready returns 1 one cycle after the out handshake.
- Single-sample frame (in_last on the first sample): out_min=out_max=sample, out_count=1.
- in_last on the FRAME_LEN-th sample: frame ends once; no duplicate result.
- in_data and in_last are ignored when in_valid=0. in_valid while in_ready=0 is legal; the sample is held by the producer.
- Outputs stay stable in HOLD regardless of input activity.
- Reset mid-frame or in HOLD: immediate return to reset values. The partial frame is discarded and no result is emitted.

Optional Feature:
- MINMAX_INDEX_EN defined:
  - Adds outputs out_min_idx and out_max_idx, CW bits wide: the 0-based position in the frame of the first occurrence of min and of max.
  - Both reset to 0 and are loaded alongside out_min/out_max.
- Undefined: ports and index registers are absent; all other behaviour is identical.

Decomposition:
- Package minmax_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t.
  - A helper function for computing CW.
- One sub-module, ult_cmp: combinational N-bit borrow-based unsigned less-than. Instantiated twice (min path, max path).
- The FSM and registers stay in minmax_tracker.

Test Plan (N=4, FRAME_LEN=4):
- Full frame 0010,1110,0111,0101, no in_last, out_ready=1 -> out_valid 1 cycle after the 4th accept; min=0010, max=1110, count=4; in_ready low during HOLD.
- Early end: 1000, then 0011 with in_last=1 -> min=0011, max=1000, count=2.
- Ties and single sample: frame 0110,0110,0110,0110 -> min=max=0110. Under MINMAX_INDEX_EN, both indices=0. A single-sample frame 1111 with in_last -> min=max=1111, count=1.
- Backpressure: out_ready=0 for 5 cycles after the result, with in_valid held high at 0001 -> in_ready=0 and outputs stable the whole time; no sample consumed until 1 cycle after out_ready=1.
- Boundaries: samples 0000 and 1111 in one frame -> min=0000, max=1111; confirms no signed or overflow error in the borrow logic.
- Reset mid-frame: assert rst_n=0 after 2 accepts -> all outputs 0 immediately. Next full frame 0100,0010,1010,1000 -> min=0010, max=1010, count=4 with no stale data.

Source files
------------

// File: rtl/minmax_pkg.sv
// Shared types and helpers for the min/max tracker slice.
package minmax_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic int calc_cw(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/minmax_tracker_ult_cmp.sv
// Combinational N-bit unsigned less-than, taken as the borrow out of a - b.
module ult_cmp #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt
);

    logic [N:0] borrow;

    // Ripple borrow chain; the final borrow is set exactly when a < b.
    always_comb begin
        borrow = '0;
        for (int i = 0; i < N; i++) begin
            borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
        end
    end

    assign lt = borrow[N];

endmodule

// File: rtl/minmax_tracker.sv
// Per-frame running min/max/count over a valid/ready sample stream.
// Optional MINMAX_INDEX_EN adds first-occurrence indices of min and max.
module minmax_tracker
    import minmax_pkg::*;
#(
    parameter  int N         = 4,
    parameter  int FRAME_LEN = 8,
    localparam int CW        = calc_cw(FRAME_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_min,
    output logic [N-1:0]  out_max,
    output logic [CW-1:0] out_count
`ifdef MINMAX_INDEX_EN
   ,output logic [CW-1:0] out_min_idx,
    output logic [CW-1:0] out_max_idx
`endif
);

    localparam logic [CW-1:0] FRAME_LEN_CW = CW'(FRAME_LEN);

    state_t         state, nxt_state;
    logic           ready_q;
    logic [CW-1:0]  cnt, nxt_cnt;
    logic [N-1:0]   run_min, run_max, nxt_min, nxt_max;
    logic           min_lt, max_lt, first, accept, last_hit;

    ult_cmp #(.N(N)) u_min_cmp (.a(in_data), .b(run_min), .lt(min_lt));
    ult_cmp #(.N(N)) u_max_cmp (.a(run_max), .b(in_data), .lt(max_lt));

    assign in_ready  = ready_q;
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && ready_q;
    assign first     = (state == IDLE);
    assign nxt_cnt   = first ? CW'(1) : cnt + CW'(1);
    assign nxt_min   = (first || min_lt) ? in_data : run_min;
    assign nxt_max   = (first || max_lt) ? in_data : run_max;
    assign last_hit  = in_last || (nxt_cnt == FRAME_LEN_CW);

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE, ACCUM: if (accept) nxt_state = last_hit ? HOLD : ACCUM;
            HOLD:        if (out_ready) nxt_state = IDLE;
            default:     nxt_state = IDLE;
        endcase
    end

    // in_ready is registered so it stays low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready_q   <= 1'b0;
            cnt       <= '0;
            run_min   <= '0;
            run_max   <= '0;
            out_min   <= '0;
            out_max   <= '0;
            out_count <= '0;
        end else begin
            state   <= nxt_state;
            ready_q <= (nxt_state != HOLD);
            if (accept) begin
                run_min <= nxt_min;
                run_max <= nxt_max;
                cnt     <= nxt_cnt;
                if (last_hit) begin
                    out_min   <= nxt_min;
                    out_max   <= nxt_max;
                    out_count <= nxt_cnt;
                end
            end else if (state == HOLD && out_ready) begin
                cnt <= '0;
            end
        end
    end

`ifdef MINMAX_INDEX_EN
    logic [CW-1:0] run_min_idx, run_max_idx, cur_idx, nxt_min_idx, nxt_max_idx;

    assign cur_idx     = first ? '0 : cnt;
    assign nxt_min_idx = (first || min_lt) ? cur_idx : run_min_idx;
    assign nxt_max_idx = (first || max_lt) ? cur_idx : run_max_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_min_idx <= '0;
            run_max_idx <= '0;
            out_min_idx <= '0;
            out_max_idx <= '0;
        end else if (accept) begin
            run_min_idx <= nxt_min_idx;
            run_max_idx <= nxt_max_idx;
            if (last_hit) begin
                out_min_idx <= nxt_min_idx;
                out_max_idx <= nxt_max_idx;
            end
        end
    end
`endif

endmodule
